// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector operand loader.
// The frame is 16 matrix words followed by 4 vector words.
package matvec_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } lstate_t;

   localparam int NUM_WORDS = 20;
   localparam int X_BASE    = 16;

   localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

   // A frame is malformed when in_last disagrees with the word position.
   function automatic logic frame_bad(input logic [4:0] idx, input logic last);
      return (last && (idx != LAST_IDX)) || (!last && (idx == LAST_IDX));
   endfunction

endpackage

// File: rtl/matvec_loader.sv
// Packs a 20-word serial operand frame into the 4x4 matrix / 4x1 vector buses,
// pulses mac_clear, waits COMPUTE_CYCLES and holds res_valid until res_ack.
module matvec_loader
   import matvec_pkg::*;
#(
   parameter int N              = 32,
   parameter int COMPUTE_CYCLES = 6
) (
   input  logic           clk,
   input  logic           clear,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_data,
   input  logic           in_last,
   output logic [4*N-1:0] A1,
   output logic [4*N-1:0] A2,
   output logic [4*N-1:0] A3,
   output logic [4*N-1:0] A4,
   output logic [N-1:0]   X1,
   output logic [N-1:0]   X2,
   output logic [N-1:0]   X3,
   output logic [N-1:0]   X4,
   output logic           mac_clear,
   output logic           busy,
   output logic           res_valid,
   input  logic           res_ack,
   output logic           frame_err
);

   localparam logic [3:0] CNT_INIT = 4'(COMPUTE_CYCLES - 1);

   lstate_t        r_state;
   logic [4:0]     r_idx;
   logic [3:0]     r_cnt;
   logic           r_mac_clear;
   logic           r_res_valid;
   logic           r_frame_err;
   logic [4*N-1:0] r_a [4];
   logic [N-1:0]   r_x [4];

   logic           w_xfer;
   logic           w_bad;
   logic [1:0]     w_col_inv;
   int             w_col_lsb;

   assign in_ready  = (r_state == LOAD);
   assign busy      = (r_state != LOAD);
   assign w_xfer    = in_valid && in_ready;
   assign w_bad     = frame_bad(r_idx, in_last);

   // Column 0 occupies the most significant slice of each row bus.
   assign w_col_inv = ~r_idx[1:0];
   assign w_col_lsb = int'(w_col_inv) * N;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state     <= LOAD;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_mac_clear <= 1'b0;
         r_res_valid <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_mac_clear <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            LOAD: begin
               if (w_xfer) begin
                  if (w_bad) begin
                     r_frame_err <= 1'b1;
                     r_idx       <= '0;
                  end else if (r_idx == LAST_IDX) begin
                     r_state     <= CLR;
                     r_mac_clear <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 5'd1;
                  end
               end
            end
            CLR: begin
               r_cnt   <= CNT_INIT;
               r_state <= RUN;
            end
            RUN: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= DONE;
                  r_res_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            DONE: begin
               if (res_ack) begin
                  r_state     <= LOAD;
                  r_idx       <= '0;
                  r_res_valid <= 1'b0;
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   // Only the slice addressed by idx changes; a rejected word writes nothing.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < 4; i++) begin
            r_a[i] <= '0;
            r_x[i] <= '0;
         end
      end else if (w_xfer && !w_bad) begin
         if (r_idx < 5'(X_BASE)) begin
            r_a[r_idx[3:2]][w_col_lsb +: N] <= in_data;
         end else begin
            r_x[r_idx[1:0]] <= in_data;
         end
      end
   end

   assign A1        = r_a[0];
   assign A2        = r_a[1];
   assign A3        = r_a[2];
   assign A4        = r_a[3];
   assign X1        = r_x[0];
   assign X2        = r_x[1];
   assign X3        = r_x[2];
   assign X4        = r_x[3];
   assign mac_clear = r_mac_clear;
   assign res_valid = r_res_valid;
   assign frame_err = r_frame_err;

endmodule

// File: doc/matvec_loader.md
# matvec_loader

Upstream operand stage for the 4x4 by 4x1 matrix-vector multiplier. It accepts the 16 matrix elements and 4 vector elements as a serial valid/ready word stream and packs them into the multiplier's parallel row and vector operand buses. It then issues a one-cycle restart pulse to the multiplier, holds the operands stable for a fixed compute window, and raises `res_valid` until the consumer acknowledges the result.

## Interface
- `N`, default 32: element width in bits.
- `COMPUTE_CYCLES`, default 6: number of cycles the operands are held after the restart pulse before the result is declared valid. Legal range is 1 to 15.
- `clk`, input, 1: the only clock. All logic is on the rising edge.
- `clear`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` holds a word.
- `in_ready`, output, 1: the loader can accept a word.
- `in_data`, input, N: operand word.
- `in_last`, input, 1: marks the final word of a frame.
- `A1`, `A2`, `A3`, `A4`, output, 4N each: packed matrix rows. Column 0 sits in bits [4N-1:3N] and column 3 in [N-1:0].
- `X1`, `X2`, `X3`, `X4`, output, N each: vector elements.
- `mac_clear`, output, 1: one-cycle restart pulse to the multiplier.
- `busy`, output, 1: asserted whenever the state is not LOAD.
- `res_valid`, output, 1: the multiplier outputs are final.
- `res_ack`, input, 1: the consumer has taken the result.
- `frame_err`, output, 1: one-cycle pulse on a malformed frame.

## Operation
- A frame is exactly 20 words.
  - Words 0 to 15 are the matrix in row-major order: word 4r+c goes to row r+1, column c.
  - Words 16 to 19 go to X1 through X4.
- A word transfers on any rising edge where `in_valid` and `in_ready` are both 1.
- A 5-bit word index `idx` runs from 0 to 19 and selects the destination slice.
  - Only that slice is written on a transfer.
  - All other operand bits hold their value.
- The state machine has four states: LOAD, CLR, RUN and DONE.
  - **LOAD**: `in_ready` is 1.
    - On a transfer with idx=19 and `in_last`=1, go to CLR.
    - On a transfer with idx<19, increment idx.
  - **CLR**: `mac_clear` is 1 for exactly this one cycle. `cnt` is loaded with COMPUTE_CYCLES-1. Go to RUN.
  - **RUN**: decrement `cnt` each cycle. When `cnt` is 0, go to DONE.
  - **DONE**: `res_valid` is 1. On `res_ack`=1, go to LOAD and set idx to 0.
- Framing errors:
  - A transfer with `in_last`=1 and idx<19 is an early last.
  - A transfer at idx=19 with `in_last`=0 is a missing last.
  - Either case causes the following, and the state stays LOAD:
    - `frame_err` pulses on the next cycle.
    - idx resets to 0.
    - The erroneous word is discarded.
    - Operand slices written earlier keep their values and are overwritten by the next frame.
- Operand outputs are frozen in CLR, RUN and DONE because `in_ready` is 0 there.
- `res_ack` is ignored outside DONE.
- `in_valid` outside LOAD is ignored, and no word is consumed.

## Timing
- Reset values, effective on the edge after `clear`=1:
  - State is LOAD and idx is 0.
  - All A and X outputs are 0.
  - `mac_clear`, `res_valid`, `frame_err` and `busy` are 0.
  - `in_ready` is 1.
- `clear` overrides every other input in every state.
  - Asserting it mid-frame or in RUN or DONE aborts immediately.
  - No `mac_clear` pulse is issued as a result of `clear`.
- `in_ready` is a decode of the state only. It has no combinational path from `in_valid`.
- Latency for a final word accepted at edge t:
  - `mac_clear` is high in the cycle after t.
  - `res_valid` rises COMPUTE_CYCLES+1 edges after t and stays high until the `res_ack` edge.
- Full-rate streaming loads a frame in 20 cycles. Bubbles on `in_valid` are allowed anywhere.
- `res_ack` sampled at edge u makes `in_ready` 1 after u, so the next frame can start one cycle later.
- All outputs are registered except `in_ready` and `busy`, which are state decodes.

## Structure
- Package `matvec_pkg` holds:
  - the state enum `lstate_t` with LOAD, CLR, RUN and DONE;
  - `NUM_WORDS` = 20;
  - `X_BASE` = 16.
- No sub-module is needed. The slice decoder and `cnt` are inline.
- The multiplier is instantiated by the integration level, not inside this block.

## Test plan
- **Full frame, full rate.** Send words 1 to 20 with `in_last` on word 20 and COMPUTE_CYCLES=6.
  - Expect A1 = {1,2,3,4} and A4 = {13,14,15,16}.
  - Expect X1..X4 = 17..20.
  - Expect a `mac_clear` pulse 1 cycle after the last word.
  - Expect `res_valid` 7 edges after the last word.
- **Back-pressure and bubbles.** Toggle `in_valid` randomly during a frame.
  - Expect the same packing.
  - Expect `in_ready` to stay 0 from CLR until `res_ack`, with no words consumed in that window.
- **Early last.** Assert `in_last` on word 7.
  - Expect a `frame_err` pulse.
  - Expect idx to be 0 and no `mac_clear`.
  - A following good frame must complete normally.
- **Missing last.** Send 20 words with `in_last`=0.
  - Expect `frame_err`, and the state stays LOAD.
  - Word 20 does not overwrite X4.
- **Mid-run reset.** Assert `clear` during RUN.
  - Expect all operands 0 and `res_valid` 0 on the next edge.
  - Expect `in_ready` 1 and no `mac_clear`.
- **Ack handling.** Hold `res_ack` high before DONE.
  - The early ack has no effect.
  - `res_valid` holds 1 cycle in DONE and then drops.
  - Back-to-back frames load correctly.
